// File: rtl/systolic_result_drain.sv
// Captures the systolic array's flat accumulator bus on done_in and streams it row-major over valid/ready.
// Optional signed output clamp to SAT_WIDTH when SYSTOLIC_DRAIN_SAT_EN is defined.
module systolic_result_drain #(
   parameter int unsigned N         = 4,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned SAT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       done_in,
   input  logic [N*N*ACC_WIDTH-1:0]   result_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_WIDTH-1:0]       out_data,
   output logic [$clog2(N)-1:0]       out_row,
   output logic [$clog2(N)-1:0]       out_col,
   output logic                       out_last,
   output logic                       busy,
   output logic                       overrun
);

   localparam int unsigned NE   = N * N;
   localparam int unsigned IDXW = $clog2(NE);
   localparam int unsigned RW   = $clog2(N);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NE - 1);
   localparam logic [IDXW-1:0] N_IDX    = IDXW'(N);

`ifdef SYSTOLIC_DRAIN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   // Two's complement: the clamp floor is the bitwise inverse of the ceiling.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (SAT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                 state;
   logic [IDXW-1:0]        idx;
   logic [ACC_WIDTH-1:0]   buffer [NE];

   logic                   xfer_c;
   logic                   final_c;
   logic                   capture_c;
   logic signed [ACC_WIDTH-1:0] raw_c;

   assign xfer_c    = (state == STREAM) && out_ready;
   assign final_c   = xfer_c && (idx == LAST_IDX);
   // A done on the final transfer cycle chains the next frame with no bubble.
   assign capture_c = done_in && ((state == IDLE) || final_c);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         overrun <= 1'b0;
         for (int k = 0; k < int'(NE); k++) begin
            buffer[k] <= '0;
         end
      end else begin
         overrun <= done_in && (state == STREAM) && !final_c;
         if (capture_c) begin
            for (int k = 0; k < int'(NE); k++) begin
               buffer[k] <= result_in[k*ACC_WIDTH +: ACC_WIDTH];
            end
            idx   <= '0;
            state <= STREAM;
         end else if (final_c) begin
            idx   <= '0;
            state <= IDLE;
         end else if (xfer_c) begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign out_last  = (state == STREAM) && (idx == LAST_IDX);
   assign out_row   = RW'(idx / N_IDX);
   assign out_col   = RW'(idx % N_IDX);
   assign raw_c     = buffer[idx];

   // Output mux straight off the buffer, optionally clamped.
   always_comb begin
      out_data = raw_c;
      if (SAT_EN) begin
         if (raw_c > SAT_MAX) begin
            out_data = SAT_MAX;
         end else if (raw_c < SAT_MIN) begin
            out_data = SAT_MIN;
         end
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: reset, drain, backpressure, overrun, chaining, mid-frame reset, clamp.
module tb_systolic_result_drain;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int NE = N * N;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 done_in;
   logic [NE*AW-1:0]     result_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [AW-1:0]        out_data;
   logic [1:0]           out_row;
   logic [1:0]           out_col;
   logic                 out_last;
   logic                 busy;
   logic                 overrun;

   always #5 clk = ~clk;

   systolic_result_drain #(.N(N), .ACC_WIDTH(AW), .SAT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .done_in(done_in), .result_in(result_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .busy(busy), .overrun(overrun)
   );

   int frame [NE];
   for (genvar g = 0; g < NE; g++) begin : g_bus
      assign result_in[g*AW +: AW] = frame[g];
   end

   typedef struct {
      int data;
      int row;
      int col;
      int last;
   } exp_t;

   typedef struct {
      int val;
      int exp_raw;
      int exp_sat;
   } sat_vec_t;

   exp_t     sb [$];
   sat_vec_t tbl [5];
   int       checks   = 0;
   int       failures = 0;
   bit       exp_ovr  = 1'b0;
   bit       stalled  = 1'b0;
   int       h_data, h_row, h_col, h_last;

   function automatic int model_out(input int v);
`ifdef SYSTOLIC_DRAIN_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
`endif
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: check settled outputs, apply inputs, update the model, advance to 1 time unit after the edge.
   task automatic tick(input bit d, input bit r);
      exp_t e;
      bit   acc;
      chk("valid", int'(out_valid), int'(sb.size() > 0));
      chk("busy", int'(busy), int'(sb.size() > 0));
      chk("overrun", int'(overrun), int'(exp_ovr));
      if (sb.size() == 0) chk("last_idle", int'(out_last), 0);
      if (stalled) begin
         chk("hold_data", $signed(out_data), h_data);
         chk("hold_row", int'(out_row), h_row);
         chk("hold_col", int'(out_col), h_col);
         chk("hold_last", int'(out_last), h_last);
      end
      done_in   = d;
      out_ready = r;
      if (sb.size() > 0 && r) begin
         e = sb.pop_front();
         chk("data", $signed(out_data), e.data);
         chk("row", int'(out_row), e.row);
         chk("col", int'(out_col), e.col);
         chk("last", int'(out_last), e.last);
         stalled = 1'b0;
      end else begin
         stalled = (sb.size() > 0);
         h_data  = $signed(out_data);
         h_row   = int'(out_row);
         h_col   = int'(out_col);
         h_last  = int'(out_last);
      end
      acc     = d && (sb.size() == 0);
      exp_ovr = d && !acc;
      if (acc) begin
         for (int k = 0; k < NE; k++) begin
            e.data = model_out(frame[k]);
            e.row  = k / N;
            e.col  = k % N;
            e.last = int'(k == NE - 1);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input bit d);
      rst_n   = 1'b0;
      done_in = d;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", $signed(out_data), 0);
      chk("rst_row", int'(out_row), 0);
      chk("rst_col", int'(out_col), 0);
      chk("rst_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n   = 1'b1;
      done_in = 1'b0;
      sb.delete();
      exp_ovr = 1'b0;
      stalled = 1'b0;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (sb.size() > 0 && c < budget) begin
         tick(1'b0, 1'b1);
         c++;
      end
      chk("drain_done", sb.size(), 0);
   endtask

   task automatic set_ramp();
      for (int k = 0; k < NE; k++) frame[k] = k + 1;
   endtask

   initial begin
      tbl[0] = '{300, 300, 127};
      tbl[1] = '{-1000, -1000, -128};
      tbl[2] = '{127, 127, 127};
      tbl[3] = '{-128, -128, -128};
      tbl[4] = '{0, 0, 0};

      rst_n     = 1'b0;
      done_in   = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < NE; k++) frame[k] = 0;

      // reset with done held high, then idle
      set_ramp();
      do_reset(2, 1'b1);
      repeat (5) tick(1'b0, 1'b0);

      // basic drain at full rate, then one idle cycle
      set_ramp();
      tick(1'b1, 1'b1);
      drain(20);
      tick(1'b0, 1'b1);

      // backpressure with ready pattern 1,0,0,...
      tick(1'b1, 1'b1);
      for (int c = 0; c < 100 && sb.size() > 0; c++) tick(1'b0, (c % 3) == 0);
      chk("bp_done", sb.size(), 0);
      tick(1'b0, 1'b0);

      // overrun mid-frame, then chained frame on the final transfer
      tick(1'b1, 1'b1);
      repeat (4) tick(1'b0, 1'b1);
      for (int k = 0; k < NE; k++) frame[k] = 32'h77;
      tick(1'b1, 1'b1);
      for (int c = 0; c < 30 && sb.size() > 1; c++) tick(1'b0, 1'b1);
      chk("pre_final", sb.size(), 1);
      tick(1'b1, 1'b1);
      drain(20);
      tick(1'b0, 1'b0);

      // reset mid-frame, then restart
      set_ramp();
      tick(1'b1, 1'b1);
      repeat (7) tick(1'b0, 1'b1);
      do_reset(1, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      drain(20);

      // clamp table
      for (int k = 0; k < NE; k++) frame[k] = 0;
      for (int i = 0; i < 5; i++) frame[i] = tbl[i].val;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
`ifdef SYSTOLIC_DRAIN_SAT_EN
         chk("sat_tbl", $signed(out_data), tbl[i].exp_sat);
`else
         chk("raw_tbl", $signed(out_data), tbl[i].exp_raw);
`endif
         tick(1'b0, 1'b1);
      end
      drain(20);
      tick(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
